// File: rtl/vga_pkg.sv
// Purpose: timing-set types and standard VGA mode constants for the timing generator.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package vga_pkg;

  typedef enum logic {NEG = 1'b0, POS = 1'b1} sync_pol_t;

  // One display axis. All values are in counts of that axis (pixels or lines).
  typedef struct packed {
    logic [15:0] pixels;
    logic [15:0] total;
    logic [15:0] sync_start;
    logic [15:0] sync_time;
    sync_pol_t   sync_pol;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_1024X768_60 = '{
    h: '{pixels: 16'd1024, total: 16'd1344, sync_start: 16'd1048, sync_time: 16'd136, sync_pol: NEG},
    v: '{pixels: 16'd768,  total: 16'd806,  sync_start: 16'd771,  sync_time: 16'd6,   sync_pol: NEG}
  };

  localparam vga_timing_t VGA_800X600_60 = '{
    h: '{pixels: 16'd800,  total: 16'd1056, sync_start: 16'd840,  sync_time: 16'd128, sync_pol: POS},
    v: '{pixels: 16'd600,  total: 16'd628,  sync_start: 16'd601,  sync_time: 16'd4,   sync_pol: POS}
  };

  // True when an axis can be counted by a w-bit counter and its sync/blank
  // windows lie inside the line or frame.
  function automatic logic axis_fits(input vga_axis_t ax, input int w);
    return (ax.total != 16'd0) &&
           (int'(ax.total) <= (1 << w)) &&
           (ax.pixels <= ax.total) &&
           ((int'(ax.sync_start) + int'(ax.sync_time)) <= int'(ax.total));
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Purpose: bundle of the timing generator's control inputs and raster outputs.
// Latency: n/a (wiring only).
// Backpressure: none; pix_en is the only pacing input.
// Ports: pix_en, mode_sel (consumer -> generator); hcount, vcount, hsync, vsync,
//        hblnk, vblnk, line_start, frame_start, mode_act, frame_cnt (generator -> consumer).
//        frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int HCNT_W = 11,
  parameter int VCNT_W = 10
);

  logic              pix_en;
  logic              mode_sel;
  logic [HCNT_W-1:0] hcount;
  logic [VCNT_W-1:0] vcount;
  logic              hsync;
  logic              vsync;
  logic              hblnk;
  logic              vblnk;
  logic              line_start;
  logic              frame_start;
  logic              mode_act;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  modport master (
    input  pix_en, mode_sel,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start, mode_act
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output pix_en, mode_sel,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start, mode_act
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Purpose: one raster axis: wrapping position counter with registered sync and blank decode.
// Latency: sync/blank decoded from the next count, so they line up with cnt in the same cycle.
// Backpressure: en=0 holds every register.
// Ports: clk, rst_n (sync, active low); en advance; last = final count of the active timing;
//        dec_* = decode window of the timing that applies to the next count;
//        cnt, wrap (cnt==last, combinational), sync, blnk.
module vga_axis_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] last,
  input  logic [W-1:0] dec_pixels,
  input  logic [W-1:0] dec_sync_start,
  input  logic [W:0]   dec_sync_end,
  input  logic         dec_sync_pos,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync,
  output logic         blnk
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sync_q, sync_d;
  logic         blnk_q, blnk_d;
  logic         sync_act;

  assign wrap = (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    // Sync window end is one bit wider so start+time cannot overflow the counter width.
    sync_act = (cnt_d >= dec_sync_start) && ({1'b0, cnt_d} < dec_sync_end);
    sync_d   = sync_act ? dec_sync_pos : ~dec_sync_pos;
    blnk_d   = (cnt_d >= dec_pixels);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sync_q <= ~dec_sync_pos;
      blnk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
      blnk_q <= blnk_d;
    end
  end

  assign cnt  = cnt_q;
  assign sync = sync_q;
  assign blnk = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: dual-mode VGA raster timing; timing set switches only on the (last,last)->(0,0) wrap.
// Latency: all outputs registered; sync/blank/strobes align with hcount/vcount in the same cycle.
// Backpressure: pix_en=0 holds all state and forces line_start/frame_start low.
// Ports: clk, rst_n (sync, active low); vga (master modport): pix_en, mode_sel in;
//        hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start, mode_act out.
// Option: VGA_FRAME_CNT_EN adds the 16-bit wrapping frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          HCNT_W = 11,
  parameter int          VCNT_W = 10,
  parameter vga_timing_t MODE0  = VGA_1024X768_60,
  parameter vga_timing_t MODE1  = VGA_800X600_60
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  if (!axis_fits(MODE0.h, HCNT_W) || !axis_fits(MODE1.h, HCNT_W) ||
      !axis_fits(MODE0.v, VCNT_W) || !axis_fits(MODE1.v, VCNT_W)) begin : g_bad_mode
    $error("vga_timing_gen: mode timing does not fit HCNT_W/VCNT_W counters");
  end

  localparam logic [HCNT_W-1:0] H0_LAST = HCNT_W'(MODE0.h.total - 16'd1);
  localparam logic [HCNT_W-1:0] H1_LAST = HCNT_W'(MODE1.h.total - 16'd1);
  localparam logic [VCNT_W-1:0] V0_LAST = VCNT_W'(MODE0.v.total - 16'd1);
  localparam logic [VCNT_W-1:0] V1_LAST = VCNT_W'(MODE1.v.total - 16'd1);

  localparam logic [HCNT_W-1:0] H0_PIX = HCNT_W'(MODE0.h.pixels);
  localparam logic [HCNT_W-1:0] H1_PIX = HCNT_W'(MODE1.h.pixels);
  localparam logic [VCNT_W-1:0] V0_PIX = VCNT_W'(MODE0.v.pixels);
  localparam logic [VCNT_W-1:0] V1_PIX = VCNT_W'(MODE1.v.pixels);

  localparam logic [HCNT_W-1:0] H0_SS = HCNT_W'(MODE0.h.sync_start);
  localparam logic [HCNT_W-1:0] H1_SS = HCNT_W'(MODE1.h.sync_start);
  localparam logic [VCNT_W-1:0] V0_SS = VCNT_W'(MODE0.v.sync_start);
  localparam logic [VCNT_W-1:0] V1_SS = VCNT_W'(MODE1.v.sync_start);

  localparam logic [HCNT_W:0] H0_SE = (HCNT_W+1)'(MODE0.h.sync_start + MODE0.h.sync_time);
  localparam logic [HCNT_W:0] H1_SE = (HCNT_W+1)'(MODE1.h.sync_start + MODE1.h.sync_time);
  localparam logic [VCNT_W:0] V0_SE = (VCNT_W+1)'(MODE0.v.sync_start + MODE0.v.sync_time);
  localparam logic [VCNT_W:0] V1_SE = (VCNT_W+1)'(MODE1.v.sync_start + MODE1.v.sync_time);

  localparam logic H0_POS = (MODE0.h.sync_pol == POS);
  localparam logic H1_POS = (MODE1.h.sync_pol == POS);
  localparam logic V0_POS = (MODE0.v.sync_pol == POS);
  localparam logic V1_POS = (MODE1.v.sync_pol == POS);

  logic mode_q, mode_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

  logic              h_wrap, v_wrap, v_en;
  logic [HCNT_W-1:0] h_last, h_pix, h_ss;
  logic [HCNT_W:0]   h_se;
  logic [VCNT_W-1:0] v_last, v_pix, v_ss;
  logic [VCNT_W:0]   v_se;
  logic              h_pos, v_pos;

  always_comb begin
    // The mode loads on the frame wrap (and in reset) so the decode of the
    // next count must already use the timing selected by mode_d.
    mode_d = mode_q;
    if (!rst_n || (vga.pix_en && h_wrap && v_wrap)) begin
      mode_d = vga.mode_sel;
    end

    // Wrap points follow the timing in use for the current count.
    h_last = mode_q ? H1_LAST : H0_LAST;
    v_last = mode_q ? V1_LAST : V0_LAST;

    h_pix  = mode_d ? H1_PIX : H0_PIX;
    h_ss   = mode_d ? H1_SS  : H0_SS;
    h_se   = mode_d ? H1_SE  : H0_SE;
    h_pos  = mode_d ? H1_POS : H0_POS;
    v_pix  = mode_d ? V1_PIX : V0_PIX;
    v_ss   = mode_d ? V1_SS  : V0_SS;
    v_se   = mode_d ? V1_SE  : V0_SE;
    v_pos  = mode_d ? V1_POS : V0_POS;

    v_en          = vga.pix_en & h_wrap;
    line_start_d  = vga.pix_en & h_wrap;
    frame_start_d = vga.pix_en & h_wrap & v_wrap;
`ifdef VGA_FRAME_CNT_EN
    frame_cnt_d   = frame_cnt_q + 16'(frame_start_d);
`endif
  end

  vga_axis_counter #(.W(HCNT_W)) u_h (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (vga.pix_en),
    .last           (h_last),
    .dec_pixels     (h_pix),
    .dec_sync_start (h_ss),
    .dec_sync_end   (h_se),
    .dec_sync_pos   (h_pos),
    .cnt            (vga.hcount),
    .wrap           (h_wrap),
    .sync           (vga.hsync),
    .blnk           (vga.hblnk)
  );

  vga_axis_counter #(.W(VCNT_W)) u_v (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (v_en),
    .last           (v_last),
    .dec_pixels     (v_pix),
    .dec_sync_start (v_ss),
    .dec_sync_end   (v_se),
    .dec_sync_pos   (v_pos),
    .cnt            (vga.vcount),
    .wrap           (v_wrap),
    .sync           (vga.vsync),
    .blnk           (vga.vblnk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q        <= vga.mode_sel;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q   <= 16'd0;
`endif
    end else begin
      mode_q        <= mode_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign vga.mode_act    = mode_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
  assign vga.frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: directed checks of vga_timing_gen: a full-size instance for the real line timings
// and a small-timing instance for frame, mode-switch, pix_en and mid-frame reset behaviour.
// Latency/backpressure: inputs driven 1 time unit after posedge, outputs sampled at the same point.
module tb_vga_timing_gen;
  import vga_pkg::*;

  // Small timing sets so whole frames take tens of clocks.
  localparam vga_timing_t T_A = '{
    h: '{pixels: 16'd8, total: 16'd12, sync_start: 16'd9, sync_time: 16'd2, sync_pol: NEG},
    v: '{pixels: 16'd4, total: 16'd7,  sync_start: 16'd5, sync_time: 16'd1, sync_pol: NEG}
  };
  localparam vga_timing_t T_B = '{
    h: '{pixels: 16'd6, total: 16'd10, sync_start: 16'd7, sync_time: 16'd2, sync_pol: POS},
    v: '{pixels: 16'd3, total: 16'd5,  sync_start: 16'd4, sync_time: 16'd1, sync_pol: POS}
  };

  logic clk = 1'b0;
  logic rst_n_f, rst_n_s;
  always #5 clk = ~clk;

  vga_timing_gen_if if_f ();
  vga_timing_gen_if if_s ();

  vga_timing_gen u_full (.clk(clk), .rst_n(rst_n_f), .vga(if_f));
  vga_timing_gen #(.MODE0(T_A), .MODE1(T_B)) u_small (.clk(clk), .rst_n(rst_n_s), .vga(if_s));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int o_h, o_v, o_hs, o_vs, o_hb, o_vb, o_ls, o_fs, o_ma;

  task automatic sample(input bit sm);
    if (sm) begin
      o_h = int'(if_s.hcount); o_v = int'(if_s.vcount);
      o_hs = int'(if_s.hsync); o_vs = int'(if_s.vsync);
      o_hb = int'(if_s.hblnk); o_vb = int'(if_s.vblnk);
      o_ls = int'(if_s.line_start); o_fs = int'(if_s.frame_start);
      o_ma = int'(if_s.mode_act);
    end else begin
      o_h = int'(if_f.hcount); o_v = int'(if_f.vcount);
      o_hs = int'(if_f.hsync); o_vs = int'(if_f.vsync);
      o_hb = int'(if_f.hblnk); o_vb = int'(if_f.vblnk);
      o_ls = int'(if_f.line_start); o_fs = int'(if_f.frame_start);
      o_ma = int'(if_f.mode_act);
    end
  endtask

  // Statistics gathered over a run of full-rate cycles.
  int st_seq_err, st_ls_bad, st_fs_bad;
  int st_hs0_cnt, st_hs0_first, st_hs0_last, st_hs1_cnt, st_hs1_first, st_hs1_last;
  int st_vs0_cnt, st_vs0_first, st_vs0_last, st_vs1_cnt, st_vs1_first;
  int st_hb_cnt, st_hb_first, st_vb_cnt, st_vb_first;
  int st_ls_cnt, st_ls_prev, st_ls_gap, st_fs_cnt, st_fs_prev, st_fs_gap;

  task automatic run_stats(input bit sm, input int ncyc, input int h_last, input int v_last);
    int ph, pv, eh, ev;
    st_seq_err = 0; st_ls_bad = 0; st_fs_bad = 0;
    st_hs0_cnt = 0; st_hs0_first = -1; st_hs0_last = -1;
    st_hs1_cnt = 0; st_hs1_first = -1; st_hs1_last = -1;
    st_vs0_cnt = 0; st_vs0_first = -1; st_vs0_last = -1;
    st_vs1_cnt = 0; st_vs1_first = -1;
    st_hb_cnt = 0; st_hb_first = -1; st_vb_cnt = 0; st_vb_first = -1;
    st_ls_cnt = 0; st_ls_prev = -1; st_ls_gap = -1;
    st_fs_cnt = 0; st_fs_prev = -1; st_fs_gap = -1;
    sample(sm);
    ph = o_h; pv = o_v;
    for (int i = 0; i < ncyc; i++) begin
      step();
      sample(sm);
      eh = (ph == h_last) ? 0 : ph + 1;
      ev = (ph == h_last) ? ((pv == v_last) ? 0 : pv + 1) : pv;
      if (o_h != eh || o_v != ev) st_seq_err++;
      if (o_hs == 0) begin
        st_hs0_cnt++; if (st_hs0_first < 0) st_hs0_first = o_h; st_hs0_last = o_h;
      end else begin
        st_hs1_cnt++; if (st_hs1_first < 0) st_hs1_first = o_h; st_hs1_last = o_h;
      end
      if (o_vs == 0) begin
        st_vs0_cnt++; if (st_vs0_first < 0) st_vs0_first = o_v; st_vs0_last = o_v;
      end else begin
        st_vs1_cnt++; if (st_vs1_first < 0) st_vs1_first = o_v;
      end
      if (o_hb != 0) begin st_hb_cnt++; if (st_hb_first < 0) st_hb_first = o_h; end
      if (o_vb != 0) begin st_vb_cnt++; if (st_vb_first < 0) st_vb_first = o_v; end
      if (o_ls != int'(o_h == 0)) st_ls_bad++;
      if (o_fs != int'(o_h == 0 && o_v == 0)) st_fs_bad++;
      if (o_ls != 0) begin st_ls_cnt++; st_ls_gap = i - st_ls_prev; st_ls_prev = i; end
      if (o_fs != 0) begin st_fs_cnt++; st_fs_gap = i - st_fs_prev; st_fs_prev = i; end
      ph = o_h; pv = o_v;
    end
  endtask

  task automatic wait_pos(input int h, input int v, input int budget);
    int n;
    n = 0;
    sample(1'b1);
    while (!(o_h == h && o_v == v) && n < budget) begin
      step(); sample(1'b1); n++;
    end
    if (n >= budget) chk("wait_pos timeout", o_h, h);
  endtask

  // Steps the small instance until frame_start; counts mode_act changes seen before it.
  task automatic wait_fs(input int budget, output int early);
    int n, ma0;
    n = 0; early = 0;
    sample(1'b1);
    ma0 = o_ma;
    do begin
      step(); sample(1'b1); n++;
      if (o_fs == 0 && o_ma != ma0) early++;
    end while (o_fs == 0 && n < budget);
    if (o_fs == 0) chk("wait_fs timeout", o_fs, 1);
  endtask

  initial begin
    int early, err, bad_strobe, ls_n, fs_n, eh, ev, ph, pv;
    bit en;

    // ---- 1: reset, mode_sel=0 ----
    rst_n_f = 1'b0; rst_n_s = 1'b0;
    if_f.pix_en = 1'b1; if_f.mode_sel = 1'b0;
    if_s.pix_en = 1'b1; if_s.mode_sel = 1'b0;
    repeat (3) step();
    sample(1'b0);
    chk("rst hcount", o_h, 0);
    chk("rst vcount", o_v, 0);
    chk("rst hsync", o_hs, 1);
    chk("rst vsync", o_vs, 1);
    chk("rst hblnk", o_hb, 0);
    chk("rst vblnk", o_vb, 0);
    chk("rst line_start", o_ls, 0);
    chk("rst frame_start", o_fs, 0);
    chk("rst mode_act", o_ma, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("rst frame_cnt", int'(if_f.frame_cnt), 0);
`endif
    rst_n_f = 1'b1; rst_n_s = 1'b1;
    step();
    sample(1'b0);
    chk("first hcount", o_h, 1);
    chk("first vcount", o_v, 0);

    // ---- 2: mode0 line timing on the full-size instance, two lines ----
    run_stats(1'b0, 2 * 1344, 1343, 805);
    chk("m0 seq", st_seq_err, 0);
    chk("m0 hsync low cnt", st_hs0_cnt, 272);
    chk("m0 hsync low first", st_hs0_first, 1048);
    chk("m0 hsync low last", st_hs0_last, 1183);
    chk("m0 hblnk cnt", st_hb_cnt, 640);
    chk("m0 hblnk first", st_hb_first, 1024);
    chk("m0 line_start cnt", st_ls_cnt, 2);
    chk("m0 line_start gap", st_ls_gap, 1344);
    chk("m0 line_start pos", st_ls_bad, 0);
    chk("m0 vsync low cnt", st_vs0_cnt, 0);

    // ---- mode1 line timing: reset with mode_sel=1 loads it directly ----
    rst_n_f = 1'b0; if_f.mode_sel = 1'b1;
    repeat (3) step();
    sample(1'b0);
    chk("rst1 mode_act", o_ma, 1);
    chk("rst1 hsync", o_hs, 0);
    chk("rst1 vsync", o_vs, 0);
    rst_n_f = 1'b1;
    step();
    run_stats(1'b0, 2 * 1056, 1055, 627);
    chk("m1 seq", st_seq_err, 0);
    chk("m1 hsync high cnt", st_hs1_cnt, 256);
    chk("m1 hsync high first", st_hs1_first, 840);
    chk("m1 hsync high last", st_hs1_last, 967);
    chk("m1 hblnk cnt", st_hb_cnt, 512);
    chk("m1 hblnk first", st_hb_first, 800);
    chk("m1 line_start gap", st_ls_gap, 1056);

    // ---- 3: frame timing on the small instance, mode A, two frames ----
    rst_n_s = 1'b0; if_s.mode_sel = 1'b0;
    repeat (2) step();
    rst_n_s = 1'b1;
    step();
    run_stats(1'b1, 2 * 84, 11, 6);
    chk("fA seq", st_seq_err, 0);
    chk("fA vsync low cnt", st_vs0_cnt, 24);
    chk("fA vsync low first", st_vs0_first, 5);
    chk("fA vsync low last", st_vs0_last, 5);
    chk("fA vblnk cnt", st_vb_cnt, 72);
    chk("fA vblnk first", st_vb_first, 4);
    chk("fA hsync low cnt", st_hs0_cnt, 28);
    chk("fA hsync low first", st_hs0_first, 9);
    chk("fA hsync low last", st_hs0_last, 10);
    chk("fA line_start cnt", st_ls_cnt, 14);
    chk("fA frame_start cnt", st_fs_cnt, 2);
    chk("fA frame_start gap", st_fs_gap, 84);
    chk("fA frame_start pos", st_fs_bad, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("fA frame_cnt", int'(if_s.frame_cnt), 2);
`endif

    // ---- 4: mode switch requested mid-frame ----
    wait_pos(5, 2, 200);
    if_s.mode_sel = 1'b1;
    wait_fs(200, early);
    chk("sw early mode_act", early, 0);
    chk("sw mode_act", o_ma, 1);
    chk("sw hcount", o_h, 0);
    chk("sw vcount", o_v, 0);
    chk("sw hsync idle", o_hs, 0);
    chk("sw vsync idle", o_vs, 0);
    run_stats(1'b1, 50, 9, 4);
    chk("fB seq", st_seq_err, 0);
    chk("fB hsync high cnt", st_hs1_cnt, 10);
    chk("fB hsync high first", st_hs1_first, 7);
    chk("fB hsync high last", st_hs1_last, 8);
    chk("fB hblnk cnt", st_hb_cnt, 20);
    chk("fB hblnk first", st_hb_first, 6);
    chk("fB vsync high cnt", st_vs1_cnt, 10);
    chk("fB vsync high first", st_vs1_first, 4);
    chk("fB vblnk cnt", st_vb_cnt, 20);
    chk("fB vblnk first", st_vb_first, 3);
    chk("fB line_start cnt", st_ls_cnt, 5);
    chk("fB line_start gap", st_ls_gap, 10);
    chk("fB frame_start cnt", st_fs_cnt, 1);

    // Request toggled away and back before the boundary: no switch.
    wait_pos(3, 2, 100);
    if_s.mode_sel = 1'b0;
    repeat (3) step();
    if_s.mode_sel = 1'b1;
    wait_fs(100, early);
    chk("toggle early", early, 0);
    chk("toggle mode_act", o_ma, 1);

    // ---- 5: pix_en alternating 1,0 for 100 enabled cycles, mode B from (0,0) ----
    err = 0; bad_strobe = 0; ls_n = 0; fs_n = 0;
    sample(1'b1);
    ph = o_h; pv = o_v;
    for (int i = 0; i < 200; i++) begin
      en = (i % 2) == 0;
      if_s.pix_en = en;
      step();
      sample(1'b1);
      eh = ph; ev = pv;
      if (en) begin
        eh = (ph == 9) ? 0 : ph + 1;
        ev = (ph == 9) ? ((pv == 4) ? 0 : pv + 1) : pv;
      end
      if (o_h != eh || o_v != ev) err++;
      if (!en && (o_ls != 0 || o_fs != 0)) bad_strobe++;
      if (o_ls != 0) ls_n++;
      if (o_fs != 0) fs_n++;
      ph = o_h; pv = o_v;
    end
    if_s.pix_en = 1'b1;
    chk("pix_en count seq", err, 0);
    chk("pix_en strobe when off", bad_strobe, 0);
    chk("pix_en line_start cnt", ls_n, 10);
    chk("pix_en frame_start cnt", fs_n, 2);
    chk("pix_en end hcount", o_h, 0);
    chk("pix_en end vcount", o_v, 0);

    // ---- 6: mid-frame reset while in mode B, mode_sel=0 ----
    wait_pos(7, 3, 100);
    rst_n_s = 1'b0; if_s.mode_sel = 1'b0;
    step();
    sample(1'b1);
    chk("mrst hcount", o_h, 0);
    chk("mrst vcount", o_v, 0);
    chk("mrst hsync", o_hs, 1);
    chk("mrst vsync", o_vs, 1);
    chk("mrst hblnk", o_hb, 0);
    chk("mrst vblnk", o_vb, 0);
    chk("mrst line_start", o_ls, 0);
    chk("mrst frame_start", o_fs, 0);
    chk("mrst mode_act", o_ma, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("mrst frame_cnt", int'(if_s.frame_cnt), 0);
`endif
    rst_n_s = 1'b1;
    step();
    sample(1'b1);
    chk("mrst release hcount", o_h, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
